// File: rtl/run_length_decoder.sv
// Escape-coded run-length decoder: literals pass through, ESC,0 emits ESC, and ESC,N,V emits V N times.
// Optional feature macro RLD_STATS_EN adds a saturating 16-bit output byte counter on port byte_count.
module run_length_decoder #(
  parameter logic [7:0] ESC = 8'h1B
) (
  input  logic        fast_clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
`ifdef RLD_STATS_EN
  ,
  output logic [15:0] byte_count
`endif
);

  typedef enum logic [1:0] {IDLE, GOT_ESC, GOT_CNT, EXPAND} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_rem;
  logic [7:0]  w_rem_nxt;
  logic [7:0]  r_data;
  logic [7:0]  w_data_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        w_in_xfer;
  logic        w_out_xfer;

  // The output register can take a new byte only when it is empty or draining this cycle.
  assign in_ready   = (r_state != EXPAND) && (!r_valid || out_ready);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_valid && out_ready;
  assign out_data   = r_data;
  assign out_valid  = r_valid;

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rem   <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid && !w_out_xfer;
    case (r_state)
      IDLE: begin
        if (w_in_xfer) begin
          if (in_data == ESC) begin
            w_state_nxt = GOT_ESC;
          end else begin
            w_data_nxt  = in_data;
            w_valid_nxt = 1'b1;
          end
        end
      end
      GOT_ESC: begin
        if (w_in_xfer) begin
          if (in_data == 8'h00) begin
            w_data_nxt  = ESC;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_rem_nxt   = in_data;
            w_state_nxt = GOT_CNT;
          end
        end
      end
      GOT_CNT: begin
        if (w_in_xfer) begin
          w_data_nxt  = in_data;
          w_valid_nxt = 1'b1;
          w_rem_nxt   = r_rem - 8'd1;
          w_state_nxt = (r_rem == 8'd1) ? IDLE : EXPAND;
        end
      end
      EXPAND: begin
        // rem counts copies still owed after the one on the output; leave at 1 so the last copy drains in IDLE.
        w_valid_nxt = 1'b1;
        if (w_out_xfer) begin
          w_rem_nxt = r_rem - 8'd1;
          if (r_rem == 8'd1) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef RLD_STATS_EN
  logic [15:0] r_byte_count;

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      r_byte_count <= 16'h0000;
    end else if (w_out_xfer && (r_byte_count != 16'hFFFF)) begin
      r_byte_count <= r_byte_count + 16'd1;
    end
  end

  assign byte_count = r_byte_count;
`endif

endmodule

// File: tb/tb_run_length_decoder.sv
// Directed self-checking bench for run_length_decoder; stats checks build only with RLD_STATS_EN.
module tb_run_length_decoder;

  logic        fast_clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef RLD_STATS_EN
  logic [15:0] byte_count;
`endif

  int tests_run;
  int tests_failed;
  int cyc;

  logic [7:0] dq[$];
  int         cq[$];
  bit         rq[$];

  run_length_decoder #(.ESC(8'h1B)) dut (
    .fast_clk  (fast_clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RLD_STATS_EN
    ,
    .byte_count(byte_count)
`endif
  );

  initial fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  always @(posedge fast_clk) cyc <= cyc + 1;

  // Output handshakes are logged half a cycle ahead of the edge that completes them.
  always @(negedge fast_clk) begin
    if (out_valid && out_ready) begin
      dq.push_back(out_data);
      cq.push_back(cyc);
      rq.push_back(in_ready);
    end
  end

  task automatic send(input logic [7:0] b, input int budget, output bit ok, output int acc);
    ok = 1'b0;
    acc = -1;
    in_data = b;
    in_valid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge fast_clk);
      if (in_ready) begin
        ok = 1'b1;
        acc = cyc;
      end
      @(posedge fast_clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge fast_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    dq.delete();
    cq.delete();
    rq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge fast_clk);
    @(negedge fast_clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid got %0b want 0", out_valid);
    end
    tests_run++;
    if (out_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_out_data got %02h want 00", out_data);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
`ifdef RLD_STATS_EN
    tests_run++;
    if (byte_count !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_byte_count got %04h want 0000", byte_count);
    end
`endif
    @(posedge fast_clk);
    #1;
    reset = 1'b1;
    wait_cycles(2);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset out_valid got %0b want 0", out_valid);
    end
  endtask

  task automatic test_literals();
    logic [7:0] exp [4];
    bit ok, ok_all;
    int acc, acc0;
    exp = '{8'h01, 8'h01, 8'h03, 8'h04};
    do_reset();
    out_ready = 1'b1;
    ok_all = 1'b1;
    acc0 = 0;
    for (int i = 0; i < 4; i++) begin
      send(exp[i], 10, ok, acc);
      ok_all &= ok;
      if (i == 0) acc0 = acc;
    end
    wait_cycles(3);
    tests_run++;
    if (ok_all !== 1'b1) begin
      tests_failed++;
      $display("FAIL literals_accept got timeout want accepted");
    end
    tests_run++;
    if (dq.size() !== 4) begin
      tests_failed++;
      $display("FAIL literals_count got %0d want 4", dq.size());
    end
    for (int i = 0; i < 4 && i < dq.size(); i++) begin
      tests_run++;
      if (dq[i] !== exp[i]) begin
        tests_failed++;
        $display("FAIL literals_data[%0d] got %02h want %02h", i, dq[i], exp[i]);
      end
      tests_run++;
      if (cq[i] !== acc0 + 1 + i) begin
        tests_failed++;
        $display("FAIL literals_cycle[%0d] got %0d want %0d", i, cq[i], acc0 + 1 + i);
      end
      tests_run++;
      if (rq[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL literals_in_ready[%0d] got %0b want 1", i, rq[i]);
      end
    end
  endtask

  task automatic test_literal_escape();
    bit ok, ok_all;
    int acc, a;
    do_reset();
    out_ready = 1'b1;
    send(8'h1B, 10, ok, a);
    ok_all = ok;
    send(8'h00, 10, ok, acc);
    ok_all &= ok;
    send(8'h07, 10, ok, acc);
    ok_all &= ok;
    wait_cycles(3);
    tests_run++;
    if (ok_all !== 1'b1) begin
      tests_failed++;
      $display("FAIL lit_esc_accept got timeout want accepted");
    end
    tests_run++;
    if (dq.size() !== 2) begin
      tests_failed++;
      $display("FAIL lit_esc_count got %0d want 2", dq.size());
    end else begin
      tests_run++;
      if (dq[0] !== 8'h1B || dq[1] !== 8'h07) begin
        tests_failed++;
        $display("FAIL lit_esc_data got %02h %02h want 1b 07", dq[0], dq[1]);
      end
      tests_run++;
      if (cq[0] !== a + 2 || cq[1] !== a + 3) begin
        tests_failed++;
        $display("FAIL lit_esc_cycle got %0d %0d want %0d %0d", cq[0], cq[1], a + 2, a + 3);
      end
    end
  endtask

  task automatic test_long_run();
    bit ok, ok_all;
    int acc, a;
    logic [7:0] expd;
    do_reset();
    out_ready = 1'b1;
    send(8'h1B, 10, ok, a);
    ok_all = ok;
    send(8'hFF, 10, ok, acc);
    ok_all &= ok;
    send(8'hAA, 10, ok, acc);
    ok_all &= ok;
    send(8'h55, 300, ok, acc);
    ok_all &= ok;
    wait_cycles(3);
    tests_run++;
    if (ok_all !== 1'b1) begin
      tests_failed++;
      $display("FAIL long_run_accept got timeout want accepted");
    end
    tests_run++;
    if (dq.size() !== 256) begin
      tests_failed++;
      $display("FAIL long_run_count got %0d want 256", dq.size());
    end
    for (int i = 0; i < 256 && i < dq.size(); i++) begin
      expd = (i < 255) ? 8'hAA : 8'h55;
      tests_run++;
      if (dq[i] !== expd) begin
        tests_failed++;
        $display("FAIL long_run_data[%0d] got %02h want %02h", i, dq[i], expd);
      end
      tests_run++;
      if (cq[i] !== a + 3 + i) begin
        tests_failed++;
        $display("FAIL long_run_cycle[%0d] got %0d want %0d", i, cq[i], a + 3 + i);
      end
      if (i < 255) begin
        tests_run++;
        if (rq[i] !== (i >= 254)) begin
          tests_failed++;
          $display("FAIL long_run_in_ready[%0d] got %0b want %0b", i, rq[i], (i >= 254));
        end
      end
    end
`ifdef RLD_STATS_EN
    tests_run++;
    if (byte_count !== 16'd256) begin
      tests_failed++;
      $display("FAIL long_run_byte_count got %0d want 256", byte_count);
    end
`endif
  endtask

  task automatic test_back_pressure();
    bit ok, ok_all, acc44;
    int acc, nx;
    logic [7:0] expd;
    do_reset();
    out_ready = 1'b1;
    send(8'h1B, 10, ok, acc);
    ok_all = ok;
    send(8'h05, 10, ok, acc);
    ok_all &= ok;
    send(8'h3C, 10, ok, acc);
    ok_all &= ok;
    in_data = 8'h44;
    in_valid = 1'b1;
    nx = 0;
    acc44 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      out_ready = ((k % 3) == 0);
      @(negedge fast_clk);
      if (!acc44 && in_valid) begin
        tests_run++;
        if (in_ready !== ((nx == 4) && out_ready)) begin
          tests_failed++;
          $display("FAIL bp_in_ready k=%0d got %0b want %0b", k, in_ready, ((nx == 4) && out_ready));
        end
        if (in_ready) acc44 = 1'b1;
      end
      if (out_valid && !out_ready) begin
        expd = (nx < 5) ? 8'h3C : 8'h44;
        tests_run++;
        if (out_data !== expd) begin
          tests_failed++;
          $display("FAIL bp_stall_data k=%0d got %02h want %02h", k, out_data, expd);
        end
      end
      if (out_valid && out_ready) nx++;
      @(posedge fast_clk);
      #1;
      if (acc44) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_cycles(2);
    tests_run++;
    if (ok_all !== 1'b1 || acc44 !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_accept got %0b%0b want 11", ok_all, acc44);
    end
    tests_run++;
    if (dq.size() !== 6) begin
      tests_failed++;
      $display("FAIL bp_count got %0d want 6", dq.size());
    end
    for (int i = 0; i < 6 && i < dq.size(); i++) begin
      expd = (i < 5) ? 8'h3C : 8'h44;
      tests_run++;
      if (dq[i] !== expd) begin
        tests_failed++;
        $display("FAIL bp_data[%0d] got %02h want %02h", i, dq[i], expd);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok, ok_all;
    int acc;
    do_reset();
    out_ready = 1'b1;
    send(8'h1B, 10, ok, acc);
    ok_all = ok;
    send(8'h0A, 10, ok, acc);
    ok_all &= ok;
    send(8'h77, 10, ok, acc);
    ok_all &= ok;
    wait_cycles(2);
    tests_run++;
    if (dq.size() !== 2) begin
      tests_failed++;
      $display("FAIL mid_reset_pre_count got %0d want 2", dq.size());
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_out_valid got %0b want 0", out_valid);
    end
    tests_run++;
    if (in_ready !== 1'b1 || out_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_reset_state got in_ready=%0b data=%02h want 1 00", in_ready, out_data);
    end
    @(posedge fast_clk);
    #1;
    reset = 1'b1;
    dq.delete();
    cq.delete();
    rq.delete();
    send(8'h12, 10, ok, acc);
    ok_all &= ok;
    wait_cycles(20);
    tests_run++;
    if (ok_all !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_accept got timeout want accepted");
    end
    tests_run++;
    if (dq.size() !== 1) begin
      tests_failed++;
      $display("FAIL mid_reset_post_count got %0d want 1", dq.size());
    end else begin
      tests_run++;
      if (dq[0] !== 8'h12) begin
        tests_failed++;
        $display("FAIL mid_reset_post_data got %02h want 12", dq[0]);
      end
    end
  endtask

  task automatic test_escape_edge();
    bit ok, ok_all;
    int acc, a;
    do_reset();
    out_ready = 1'b1;
    send(8'h1B, 10, ok, a);
    ok_all = ok;
    send(8'h1B, 10, ok, acc);
    ok_all &= ok;
    send(8'h99, 10, ok, acc);
    ok_all &= ok;
    wait_cycles(35);
    tests_run++;
    if (ok_all !== 1'b1) begin
      tests_failed++;
      $display("FAIL esc_esc_accept got timeout want accepted");
    end
    tests_run++;
    if (dq.size() !== 27) begin
      tests_failed++;
      $display("FAIL esc_esc_count got %0d want 27", dq.size());
    end
    for (int i = 0; i < 27 && i < dq.size(); i++) begin
      tests_run++;
      if (dq[i] !== 8'h99 || cq[i] !== a + 3 + i) begin
        tests_failed++;
        $display("FAIL esc_esc_copy[%0d] got %02h@%0d want 99@%0d", i, dq[i], cq[i], a + 3 + i);
      end
    end
  endtask

`ifdef RLD_STATS_EN
  task automatic test_stats_saturation();
    bit ok, ok_all;
    int acc;
    do_reset();
    out_ready = 1'b1;
    ok_all = 1'b1;
    for (int i = 0; i < 66000; i++) begin
      send(8'h01, 10, ok, acc);
      ok_all &= ok;
      if ((i % 1000) == 0) begin
        dq.delete();
        cq.delete();
        rq.delete();
      end
    end
    wait_cycles(3);
    tests_run++;
    if (ok_all !== 1'b1) begin
      tests_failed++;
      $display("FAIL stats_accept got timeout want accepted");
    end
    tests_run++;
    if (byte_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL stats_saturate got %04h want ffff", byte_count);
    end
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_literals();
    test_literal_escape();
    test_long_run();
    test_back_pressure();
    test_reset_mid_run();
    test_escape_edge();
`ifdef RLD_STATS_EN
    test_stats_saturation();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
